// File: rtl/otter_mem_port_arbiter_if.sv
// Bundle of the two requester ports, the OTTER memory data port (port 2) and BUSY.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the memory.
interface otter_mem_port_arbiter_if;
   logic        R0_REQ,   R1_REQ;
   logic        R0_WE,    R1_WE;
   logic [31:0] R0_ADDR,  R1_ADDR;
   logic [31:0] R0_WDATA, R1_WDATA;
   logic [1:0]  R0_SIZE,  R1_SIZE;
   logic        R0_SIGN,  R1_SIGN;
   logic        R0_GNT,   R1_GNT;
   logic        R0_DONE,  R1_DONE;
   logic [31:0] R0_RDATA, R1_RDATA;
   logic [31:0] MEM_ADDR2;
   logic [31:0] MEM_DIN2;
   logic        MEM_WRITE2;
   logic        MEM_READ2;
   logic [1:0]  MEM_SIZE;
   logic        MEM_SIGN;
   logic [31:0] MEM_DOUT2;
   logic        BUSY;

   modport slave (
      input  R0_REQ, R0_WE, R0_ADDR, R0_WDATA, R0_SIZE, R0_SIGN,
      input  R1_REQ, R1_WE, R1_ADDR, R1_WDATA, R1_SIZE, R1_SIGN,
      output R0_GNT, R0_DONE, R0_RDATA, R1_GNT, R1_DONE, R1_RDATA,
      output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN,
      input  MEM_DOUT2,
      output BUSY
   );

   modport master (
      output R0_REQ, R0_WE, R0_ADDR, R0_WDATA, R0_SIZE, R0_SIGN,
      output R1_REQ, R1_WE, R1_ADDR, R1_WDATA, R1_SIZE, R1_SIGN,
      input  R0_GNT, R0_DONE, R0_RDATA, R1_GNT, R1_DONE, R1_RDATA,
      input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN,
      output MEM_DOUT2,
      input  BUSY
   );
endinterface

// File: rtl/otter_mem_port_arbiter.sv
// Arbitrates between two requesters for the single OTTER memory data port and serialises their accesses.
// Reads wait a fixed RD_LATENCY, and the read data is returned to the requester that owns the access.
module otter_mem_port_arbiter #(
   parameter int RD_LATENCY = 1,   // legal range 1-4
   parameter int FIXED_PRIO = 0    // 0 = round-robin, 1 = requester 0 wins ties
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   otter_mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic        idx_q, idx_d;
   logic        last_q, last_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic win;
   logic gnt0, gnt1, done0, done1, mem_write, mem_read;

   // NOTE: every signal written here is given a default first. Without the defaults, synthesis infers latches.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      sign_d    = sign_q;
      idx_d     = idx_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      win       = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.R0_REQ || bus.R1_REQ) begin
               // On a tie, round-robin grants the requester that did not win last time.
               if (bus.R0_REQ && bus.R1_REQ) win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
               else                          win = bus.R1_REQ;
               gnt0    = ~win;
               gnt1    = win;
               we_d    = win ? bus.R1_WE    : bus.R0_WE;
               addr_d  = win ? bus.R1_ADDR  : bus.R0_ADDR;
               wdata_d = win ? bus.R1_WDATA : bus.R0_WDATA;
               size_d  = win ? bus.R1_SIZE  : bus.R0_SIZE;
               sign_d  = win ? bus.R1_SIGN  : bus.R0_SIGN;
               idx_d   = win;
               last_d  = win;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mem_write = we_q;
            mem_read  = ~we_q;
            if (we_q) begin
               // A write commits at this edge, so it completes without a response phase.
               done0   = ~idx_q;
               done1   = idx_q;
               state_d = IDLE;
            end else begin
               cnt_d   = 3'(RD_LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 3'd1) begin
               if (idx_q) rdata1_d = bus.MEM_DOUT2;
               else       rdata0_d = bus.MEM_DOUT2;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            done0   = ~idx_q;
            done1   = idx_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples its pre-edge value.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= '0;
         sign_q   <= 1'b0;
         idx_q    <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         sign_q   <= sign_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign bus.R0_GNT     = gnt0;
   assign bus.R1_GNT     = gnt1;
   assign bus.R0_DONE    = done0;
   assign bus.R1_DONE    = done1;
   assign bus.R0_RDATA   = rdata0_q;
   assign bus.R1_RDATA   = rdata1_q;
   assign bus.MEM_ADDR2  = addr_q;
   assign bus.MEM_DIN2   = wdata_q;
   assign bus.MEM_SIZE   = size_q;
   assign bus.MEM_SIGN   = sign_q;
   assign bus.MEM_WRITE2 = mem_write;
   assign bus.MEM_READ2  = mem_read;
   assign bus.BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_otter_mem_port_arbiter.sv
// Directed bench for otter_mem_port_arbiter. It uses three instances: RD_LATENCY=1 round-robin, RD_LATENCY=3 round-robin, and RD_LATENCY=1 with fixed priority.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_otter_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   done_seen;

   always #5 clk = ~clk;

   otter_mem_port_arbiter_if ia ();
   otter_mem_port_arbiter_if ib ();
   otter_mem_port_arbiter_if ic ();

   otter_mem_port_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(0)) dut_a (.CLK(clk), .RST_N(rst_n), .bus(ia.slave));
   otter_mem_port_arbiter #(.RD_LATENCY(3), .FIXED_PRIO(0)) dut_b (.CLK(clk), .RST_N(rst_n), .bus(ib.slave));
   otter_mem_port_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(1)) dut_c (.CLK(clk), .RST_N(rst_n), .bus(ic.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      {ia.R0_REQ, ia.R0_WE, ia.R0_ADDR, ia.R0_WDATA, ia.R0_SIZE, ia.R0_SIGN} = '0;
      {ia.R1_REQ, ia.R1_WE, ia.R1_ADDR, ia.R1_WDATA, ia.R1_SIZE, ia.R1_SIGN} = '0;
      {ib.R0_REQ, ib.R0_WE, ib.R0_ADDR, ib.R0_WDATA, ib.R0_SIZE, ib.R0_SIGN} = '0;
      {ib.R1_REQ, ib.R1_WE, ib.R1_ADDR, ib.R1_WDATA, ib.R1_SIZE, ib.R1_SIGN} = '0;
      {ic.R0_REQ, ic.R0_WE, ic.R0_ADDR, ic.R0_WDATA, ic.R0_SIZE, ic.R0_SIGN} = '0;
      {ic.R1_REQ, ic.R1_WE, ic.R1_ADDR, ic.R1_WDATA, ic.R1_SIZE, ic.R1_SIGN} = '0;
      ia.MEM_DOUT2 = '0;
      ib.MEM_DOUT2 = '0;
      ic.MEM_DOUT2 = '0;

      // Reset, then check the idle state.
      tick(); tick();
      smp();
      rst_n = 1'b1;
      tick();
      smp();
      check("rst_busy",  ia.BUSY, 0);
      check("rst_gnt",   {ia.R0_GNT, ia.R1_GNT}, 0);
      check("rst_done",  {ia.R0_DONE, ia.R1_DONE}, 0);
      check("rst_strb",  {ia.MEM_READ2, ia.MEM_WRITE2}, 0);
      check("rst_addr",  ia.MEM_ADDR2, 0);
      check("rst_rdata", ia.R0_RDATA | ia.R1_RDATA, 0);

      // Single read on requester 0 with RD_LATENCY=1.
      tick();
      ia.R0_REQ = 1; ia.R0_WE = 0; ia.R0_ADDR = 32'h0000_0100; ia.R0_SIZE = 2'b10;
      smp();
      check("rd_gnt0", ia.R0_GNT, 1);
      check("rd_gnt1", ia.R1_GNT, 0);
      tick();
      ia.R0_REQ = 0;
      smp();
      check("rd_issue_read",  ia.MEM_READ2, 1);
      check("rd_issue_write", ia.MEM_WRITE2, 0);
      check("rd_issue_addr",  ia.MEM_ADDR2, 32'h100);
      check("rd_issue_size",  ia.MEM_SIZE, 2'b10);
      tick();
      ia.MEM_DOUT2 = 32'hDEAD_BEEF;
      smp();
      check("rd_wait_done",  ia.R0_DONE, 0);
      check("rd_wait_strb",  ia.MEM_READ2, 0);
      check("rd_wait_addr",  ia.MEM_ADDR2, 32'h100);
      tick();
      ia.MEM_DOUT2 = 32'h0BAD_0BAD;
      smp();
      check("rd_done",  ia.R0_DONE, 1);
      check("rd_rdata", ia.R0_RDATA, 32'hDEAD_BEEF);
      tick();
      smp();
      check("rd_after_done", ia.R0_DONE, 0);
      check("rd_after_busy", ia.BUSY, 0);
      check("rd_held",       ia.R0_RDATA, 32'hDEAD_BEEF);

      // Single write on requester 1.
      tick();
      ia.R1_REQ = 1; ia.R1_WE = 1; ia.R1_ADDR = 32'h0000_2000; ia.R1_WDATA = 32'h1234_5678; ia.R1_SIZE = 2'b10;
      smp();
      check("wr_gnt1",      ia.R1_GNT, 1);
      check("wr_gnt_nodone", ia.R1_DONE, 0);
      tick();
      ia.R1_REQ = 0;
      smp();
      check("wr_strobe", ia.MEM_WRITE2, 1);
      check("wr_read",   ia.MEM_READ2, 0);
      check("wr_din",    ia.MEM_DIN2, 32'h1234_5678);
      check("wr_addr",   ia.MEM_ADDR2, 32'h2000);
      check("wr_done",   ia.R1_DONE, 1);
      tick();
      smp();
      check("wr_busy_after", ia.BUSY, 0);
      check("wr_rdata0_kept", ia.R0_RDATA, 32'hDEAD_BEEF);

      // Round-robin contention with back-to-back writes. LAST is 1, so requester 0 is granted first.
      tick();
      ia.R0_REQ = 1; ia.R0_WE = 1; ia.R0_ADDR = 32'h10; ia.R0_WDATA = 32'hAAAA_0000;
      ia.R1_REQ = 1; ia.R1_WE = 1; ia.R1_ADDR = 32'h20; ia.R1_WDATA = 32'hBBBB_1111;
      for (int i = 0; i < 8; i++) begin
         smp();
         check($sformatf("rr_gnt0_c%0d", i), ia.R0_GNT, (i % 4 == 0) ? 1 : 0);
         check($sformatf("rr_gnt1_c%0d", i), ia.R1_GNT, (i % 4 == 2) ? 1 : 0);
         check($sformatf("rr_done_c%0d", i), {ia.R1_DONE, ia.R0_DONE},
               (i % 4 == 1) ? 2'b01 : ((i % 4 == 3) ? 2'b10 : 2'b00));
         if (i % 4 == 3) check($sformatf("rr_din_c%0d", i), ia.MEM_DIN2, 32'hBBBB_1111);
         tick();
      end
      ia.R0_REQ = 0; ia.R1_REQ = 0;
      smp();
      check("rr_idle", {ia.BUSY, ia.R0_GNT, ia.R1_GNT}, 0);

      // Fields are captured only in the GNT cycle.
      tick();
      ia.R0_REQ = 1; ia.R0_WE = 1; ia.R0_ADDR = 32'h10; ia.R0_WDATA = 32'h0000_00F0;
      smp();
      check("fs_gnt", ia.R0_GNT, 1);
      tick();
      ia.R0_REQ = 0; ia.R0_ADDR = 32'h20; ia.R0_WDATA = 32'h0000_00F1;
      smp();
      check("fs_addr",  ia.MEM_ADDR2, 32'h10);
      check("fs_wdata", ia.MEM_DIN2, 32'h0000_00F0);

      // Reset during WAIT. LAST is now 0, so only the reset returns the next tie to requester 0.
      tick();
      ia.R0_REQ = 1; ia.R0_WE = 0; ia.R0_ADDR = 32'h300;
      smp();
      tick();
      ia.R0_REQ = 0;
      smp();
      check("mr_issue", ia.MEM_READ2, 1);
      tick();
      ia.MEM_DOUT2 = 32'h5555_5555;
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_busy",  ia.BUSY, 0);
      check("mr_strb",  {ia.MEM_READ2, ia.MEM_WRITE2}, 0);
      check("mr_done",  {ia.R0_DONE, ia.R1_DONE}, 0);
      check("mr_addr",  ia.MEM_ADDR2, 0);
      check("mr_rdata", ia.R0_RDATA, 0);
      smp();
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         smp();
         if (ia.R0_DONE || ia.R1_DONE) done_seen++;
      end
      check("mr_no_done_after", done_seen, 0);
      tick();
      ia.R0_REQ = 1; ia.R0_WE = 0; ia.R0_ADDR = 32'h400;
      ia.R1_REQ = 1; ia.R1_WE = 0; ia.R1_ADDR = 32'h500;
      smp();
      check("mr_tie_gnt0", ia.R0_GNT, 1);
      check("mr_tie_gnt1", ia.R1_GNT, 0);
      tick();
      ia.R0_REQ = 0; ia.R1_REQ = 0;
      tick(); tick(); tick();
      smp();
      check("mr_tie_idle", ia.BUSY, 0);

      // Latency sweep on the RD_LATENCY=3 instance. A requester 0 read first gives R0_RDATA a known value.
      tick();
      ib.R0_REQ = 1; ib.R0_WE = 0; ib.R0_ADDR = 32'h40; ib.R0_SIZE = 2'b10;
      smp();
      tick();
      ib.R0_REQ = 0;
      smp();
      for (int k = 1; k <= 4; k++) begin
         tick();
         ib.MEM_DOUT2 = (k == 3) ? 32'h1111_2222 : 32'hFFFF_0000;
         smp();
      end
      check("lat_r0_rdata", ib.R0_RDATA, 32'h1111_2222);
      tick();
      ib.R1_REQ = 1; ib.R1_WE = 0; ib.R1_ADDR = 32'h80; ib.R1_SIZE = 2'b10;
      smp();
      check("lat_gnt1", ib.R1_GNT, 1);
      tick();
      ib.R1_REQ = 0;
      smp();
      check("lat_issue", ib.MEM_READ2, 1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         ib.MEM_DOUT2 = (k == 3) ? 32'hA5A5_A5A5 : ((k == 2) ? 32'h5A5A_5A5A : 32'hFFFF_FFFF);
         smp();
         check($sformatf("lat_done_k%0d", k), ib.R1_DONE, (k == 4) ? 1 : 0);
      end
      check("lat_r1_rdata", ib.R1_RDATA, 32'hA5A5_A5A5);
      check("lat_r0_kept",  ib.R0_RDATA, 32'h1111_2222);
      tick();
      smp();
      check("lat_idle", ib.BUSY, 0);

      // Fixed priority: requester 0 wins every grant while its REQ stays high.
      tick();
      ic.R0_REQ = 1; ic.R0_WE = 1; ic.R0_ADDR = 32'h4; ic.R0_WDATA = 32'h1;
      ic.R1_REQ = 1; ic.R1_WE = 1; ic.R1_ADDR = 32'h8; ic.R1_WDATA = 32'h2;
      for (int i = 0; i < 6; i++) begin
         smp();
         check($sformatf("fp_gnt0_c%0d", i), ic.R0_GNT, (i % 2 == 0) ? 1 : 0);
         check($sformatf("fp_gnt1_c%0d", i), ic.R1_GNT, 0);
         tick();
      end
      ic.R0_REQ = 0;
      smp();
      check("fp_r1_gnt", {ic.R1_GNT, ic.R0_GNT}, 2'b10);
      tick();
      ic.R1_REQ = 0;
      smp();
      check("fp_r1_done", ic.R1_DONE, 1);
      tick();
      smp();
      check("fp_idle", ic.BUSY, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/otter_mem_port_arbiter.md
Name: otter_mem_port_arbiter

Overview:
Two-requester arbiter for the OTTER memory data port (port 2). Requester 0 is the MCU load/store path; requester 1 is a secondary master such as a debug loader or DMA engine. The block serialises their accesses onto the single synchronous data port, enforces the fixed read latency, and returns per-requester completion and read data.

Parameters:
RD_LATENCY, 1, cycles from the MEM_READ2 issue cycle to the cycle MEM_DOUT2 is valid; legal range 1-4.
FIXED_PRIO, 0, 0 selects round-robin; 1 makes requester 0 always win a tie.

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous reset, active-low
R0_REQ  input  1  requester 0 access request; held with fields stable until R0_GNT
R0_WE  input  1  requester 0: 1 = write, 0 = read
R0_ADDR  input  32  requester 0 byte address
R0_WDATA  input  32  requester 0 write data
R0_SIZE  input  2  requester 0 access size (00 byte, 01 half, 10 word)
R0_SIGN  input  1  requester 0 load sign control (1 = unsigned)
R0_GNT  output  1  one-cycle pulse; requester 0 fields captured this cycle
R0_DONE  output  1  one-cycle pulse; requester 0 access complete
R0_RDATA  output  32  requester 0 read data; valid with R0_DONE, held until its next read completes
R1_REQ, R1_WE, R1_ADDR, R1_WDATA, R1_SIZE, R1_SIGN, R1_GNT, R1_DONE, R1_RDATA: same as R0_*, for requester 1
MEM_ADDR2  output  32  memory data-port address
MEM_DIN2  output  32  memory write data
MEM_WRITE2  output  1  memory write strobe
MEM_READ2  output  1  memory read strobe
MEM_SIZE  output  2  memory access size
MEM_SIGN  output  1  memory sign control
MEM_DOUT2  input  32  memory read data
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE.
  - All GNT, DONE, MEM_WRITE2, MEM_READ2 and BUSY are 0.
  - MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN, R0_RDATA and R1_RDATA are 0.
  - Round-robin pointer LAST = 1, so requester 0 wins the first tie.
  - Reset mid-transaction abandons the transaction: no DONE and no further strobes.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no REQ is high, stay in IDLE.
  - Otherwise pick a winner. If only one REQ is high, that requester wins. If both are high, requester 0 wins when FIXED_PRIO=1; otherwise the requester not equal to LAST wins.
  - In the same cycle: assert the winner's GNT combinationally, register the winner's WE/ADDR/WDATA/SIZE/SIGN and its index, set LAST = winner, and go to ISSUE.
- ISSUE (exactly one cycle):
  - Drive MEM_* from the registered fields. MEM_WRITE2 = WE; MEM_READ2 = !WE.
  - Write: assert the winner's DONE in this cycle (write commits at this edge), then go to IDLE.
  - Read: load the latency counter with RD_LATENCY and go to WAIT.
- WAIT:
  - MEM_ADDR2, MEM_SIZE and MEM_SIGN stay held; strobes are 0.
  - Decrement the counter each cycle. MEM_DOUT2 is valid in the cycle exactly RD_LATENCY cycles after ISSUE.
  - In that cycle, capture MEM_DOUT2 into the winner's RDATA register and go to RESP.
- RESP (one cycle): pulse the winner's DONE, then go to IDLE. The other requester's RDATA is unchanged.
- Timing per access:
  - Write: GNT to DONE = 1 cycle; 2 cycles per write.
  - Read: GNT in cycle t, ISSUE in t+1, DONE in t+2+RD_LATENCY; 3+RD_LATENCY cycles per read.
- Handshake rules:
  - Requester fields are sampled only in the GNT cycle; later changes are ignored.
  - Dropping REQ before GNT withdraws the request with no side effects.
  - A REQ still high after DONE is treated as a new request.
  - REQ transitions outside IDLE are not observed until the arbiter returns to IDLE.
- At most one GNT per cycle and at most one memory strobe per cycle. GNT and DONE are never both high for the same requester in one cycle.
- Starvation bound in round-robin mode: with both requesters continuously requesting, grants alternate 0,1,0,1. No requester waits more than one other transaction.
- Addresses and sizes pass through unchecked; alignment checking belongs to memory.
- MEM_DIN2 is driven only with the registered WDATA. It holds its value outside writes, and its value is irrelevant outside writes.

Test Plan:
- Reset then single read: R0 requests a read of 0x0000_0100 with SIZE=10; memory returns 0xDEAD_BEEF at RD_LATENCY=1. Required: R0_GNT at t, MEM_READ2 at t+1 with MEM_ADDR2=0x100, R0_DONE at t+3, R0_RDATA=0xDEAD_BEEF held afterwards.
- Single write: R1 writes 0x1234_5678 to 0x0000_2000 with SIZE=10. Required: MEM_WRITE2=1 with MEM_DIN2=0x1234_5678 and R1_DONE in the same cycle, one cycle after R1_GNT; BUSY back to 0 the next cycle.
- Contention, round-robin: both REQ held continuously with writes. Required: grant order 0,1,0,1; each GNT 2 cycles apart. With FIXED_PRIO=1: only R0 is granted while R0_REQ stays high.
- Latency sweep: RD_LATENCY=3, R1 reads with MEM_DOUT2=0xA5A5_A5A5 only in cycle ISSUE+3 and garbage otherwise. Required: R1_RDATA=0xA5A5_A5A5, R1_DONE at ISSUE+4, R0_RDATA unchanged.
- Field stability: R0 changes ADDR from 0x10 to 0x20 in the cycle after R0_GNT. Required: MEM_ADDR2=0x10 at ISSUE.
- Reset mid-read: RST_N low during WAIT. Required: all outputs 0 immediately (asynchronous); no DONE after release; the next tie grants R0.
